min_pulse_width_driver: RTL and testbench

//  Transmit-side counterpart of the input glitch filter: registers N output-bound signals and

---
 rtl/min_pulse_width_driver.sv | 107 ++++++++++
 tb/tb_min_pulse_width_driver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/min_pulse_width_driver.sv
// Output-side minimum pulse width enforcer: each lane holds a driven level for MIN_*_CYCLES.
// Optional macro MPWD_LATCH_EN: latch requests seen during a hold and replay them at expiry.
module min_pulse_width_driver #(
  parameter int unsigned                  NUMBER_OF_SIGNALS = 1,
  parameter logic [NUMBER_OF_SIGNALS-1:0] RST_VALUE         = '0,
  parameter int unsigned                  MIN_HIGH_CYCLES   = 4,
  parameter int unsigned                  MIN_LOW_CYCLES    = 4,
  parameter int unsigned                  CNT_WIDTH         = 8
) (
  input  logic                         iClk,
  input  logic                         iARst,
  input  logic                         iSRst_n,
  input  logic                         iEna,
  input  logic [NUMBER_OF_SIGNALS-1:0] iSignal,
  output logic [NUMBER_OF_SIGNALS-1:0] oSignals,
  output logic [NUMBER_OF_SIGNALS-1:0] oBusy,
  output logic [NUMBER_OF_SIGNALS-1:0] oPending
);

  localparam logic [CNT_WIDTH-1:0] HighLoad = CNT_WIDTH'(MIN_HIGH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LowLoad  = CNT_WIDTH'(MIN_LOW_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);

  if (MIN_HIGH_CYCLES < 1 || MIN_LOW_CYCLES < 1) begin : gBadMin
    $error("min_pulse_width_driver: MIN_*_CYCLES must be >= 1");
  end
  if (MIN_HIGH_CYCLES >= (2 ** CNT_WIDTH) || MIN_LOW_CYCLES >= (2 ** CNT_WIDTH)) begin : gBadWidth
    $error("min_pulse_width_driver: CNT_WIDTH too narrow for MIN_*_CYCLES");
  end

  logic [NUMBER_OF_SIGNALS-1:0] sigReg;
  logic [NUMBER_OF_SIGNALS-1:0] sigNext;
  logic [NUMBER_OF_SIGNALS-1:0] reqDiff;
  logic [NUMBER_OF_SIGNALS-1:0] toggle;
  logic [CNT_WIDTH-1:0]         cnt     [NUMBER_OF_SIGNALS];
  logic [CNT_WIDTH-1:0]         cntNext [NUMBER_OF_SIGNALS];

  assign reqDiff = iSignal ^ sigReg;

`ifdef MPWD_LATCH_EN
  logic [NUMBER_OF_SIGNALS-1:0] pendReg;
  logic [NUMBER_OF_SIGNALS-1:0] pendNext;

  // A pending request forces the toggle even if the input has already returned.
  assign toggle   = reqDiff | pendReg;
  assign oPending = pendReg;
`else
  assign toggle   = reqDiff;
  assign oPending = '0;
`endif

  always_comb begin
    sigNext = sigReg;
`ifdef MPWD_LATCH_EN
    pendNext = pendReg;
`endif
    for (int i = 0; i < NUMBER_OF_SIGNALS; i++) begin
      cntNext[i] = cnt[i];
      if (cnt[i] != '0) begin
        cntNext[i] = cnt[i] - CntOne;
`ifdef MPWD_LATCH_EN
        if (reqDiff[i]) pendNext[i] = 1'b1;
`endif
      end else if (toggle[i]) begin
        sigNext[i] = ~sigReg[i];
        // Hold length follows the level being driven next, i.e. the inverse of sigReg.
        cntNext[i] = sigReg[i] ? LowLoad : HighLoad;
`ifdef MPWD_LATCH_EN
        pendNext[i] = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge iClk or posedge iARst) begin
    if (iARst) begin
      sigReg <= RST_VALUE;
      for (int i = 0; i < NUMBER_OF_SIGNALS; i++) cnt[i] <= '0;
    end else if (!iSRst_n) begin
      sigReg <= RST_VALUE;
      for (int i = 0; i < NUMBER_OF_SIGNALS; i++) cnt[i] <= '0;
    end else if (iEna) begin
      sigReg <= sigNext;
      for (int i = 0; i < NUMBER_OF_SIGNALS; i++) cnt[i] <= cntNext[i];
    end
  end

`ifdef MPWD_LATCH_EN
  always_ff @(posedge iClk or posedge iARst) begin
    if (iARst) begin
      pendReg <= '0;
    end else if (!iSRst_n) begin
      pendReg <= '0;
    end else if (iEna) begin
      pendReg <= pendNext;
    end
  end
`endif

  always_comb begin
    oBusy = '0;
    for (int i = 0; i < NUMBER_OF_SIGNALS; i++) oBusy[i] = (cnt[i] != '0);
  end

  assign oSignals = sigReg;

endmodule

// File: tb/tb_min_pulse_width_driver.sv
// Bench for min_pulse_width_driver: reference-model scoreboard plus directed timing checks.
// Honours MPWD_LATCH_EN the same way the design does.
module tb_min_pulse_width_driver;

  localparam int N     = 2;
  localparam int HIGH  = 4;
  localparam int LOW   = 3;
  localparam logic [N-1:0] RSTV = 2'b00;
`ifdef MPWD_LATCH_EN
  localparam logic LATCH = 1'b1;
`else
  localparam logic LATCH = 1'b0;
`endif

  logic         iClk;
  logic         iARst;
  logic         iSRst_n;
  logic         iEna;
  logic [N-1:0] iSignal;
  logic [N-1:0] oSignals;
  logic [N-1:0] oBusy;
  logic [N-1:0] oPending;

  int errCount   = 0;
  int checkCount = 0;

  logic [N-1:0] mSig;
  logic [N-1:0] mPend;
  int           mCnt [N];
  logic [3*N-1:0] expQ [$];

  min_pulse_width_driver #(
    .NUMBER_OF_SIGNALS(N),
    .RST_VALUE        (RSTV),
    .MIN_HIGH_CYCLES  (HIGH),
    .MIN_LOW_CYCLES   (LOW),
    .CNT_WIDTH        (8)
  ) dut (
    .iClk    (iClk),
    .iARst   (iARst),
    .iSRst_n (iSRst_n),
    .iEna    (iEna),
    .iSignal (iSignal),
    .oSignals(oSignals),
    .oBusy   (oBusy),
    .oPending(oPending)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mSig  = RSTV;
    mPend = '0;
    for (int i = 0; i < N; i++) mCnt[i] = 0;
  endtask

  function automatic logic [N-1:0] modelBusy();
    logic [N-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) b[i] = (mCnt[i] != 0);
    return b;
  endfunction

  task automatic modelStep();
    logic want;
    if (!iSRst_n) begin
      modelReset();
    end else if (iEna) begin
      for (int i = 0; i < N; i++) begin
        if (mCnt[i] != 0) begin
          mCnt[i] = mCnt[i] - 1;
          if (LATCH && (iSignal[i] != mSig[i])) mPend[i] = 1'b1;
        end else begin
          want = (iSignal[i] != mSig[i]) || (LATCH && mPend[i]);
          if (want) begin
            mSig[i]  = ~mSig[i];
            mCnt[i]  = mSig[i] ? HIGH - 1 : LOW - 1;
            mPend[i] = 1'b0;
          end
        end
      end
    end
  endtask

  // One clock: model follows the edge, expectation is queued, DUT compared 1 ns later.
  task automatic cycle();
    logic [3*N-1:0] exp;
    @(posedge iClk);
    modelStep();
    expQ.push_back({mSig, modelBusy(), mPend});
    #1;
    if (expQ.size() == 0) begin
      checkValue("sb_empty", 32'd1, 32'd0);
    end else begin
      exp = expQ.pop_front();
      checkValue("sb", 32'({oSignals, oBusy, oPending}), 32'(exp));
    end
  endtask

  initial begin
    iARst   = 1'b1;
    iSRst_n = 1'b1;
    iEna    = 1'b1;
    iSignal = '0;
    modelReset();
    #12;
    checkValue("rst_sig",  32'(oSignals), 32'(RSTV));
    checkValue("rst_busy", 32'(oBusy),    32'd0);
    checkValue("rst_pend", 32'(oPending), 32'd0);
    iARst = 1'b0;

    // Async reset mid-hold, no clock edge involved.
    iSignal = 2'b01;
    cycle();
    cycle();
    checkValue("pre_arst_sig", 32'(oSignals[0]), 32'd1);
    #3;
    iARst = 1'b1;
    #1;
    checkValue("arst_sig",  32'(oSignals), 32'(RSTV));
    checkValue("arst_busy", 32'(oBusy),    32'd0);
    modelReset();
    iSignal = '0;
    #1;
    iARst = 1'b0;
    cycle();

    // Idle lane rise, then hold enforcement (edge k = last cycle).
    iSignal = 2'b01;
    cycle();                                         // k+1
    checkValue("k1_sig",  32'(oSignals[0]), 32'd1);
    checkValue("k1_busy", 32'(oBusy[0]),    32'd1);
    cycle();                                         // k+2
    checkValue("k2_busy", 32'(oBusy[0]),    32'd1);
    iSignal = 2'b00;
    cycle();                                         // k+3
    checkValue("k3_sig",  32'(oSignals[0]), 32'd1);
    checkValue("k3_busy", 32'(oBusy[0]),    32'd1);
    cycle();                                         // k+4
    checkValue("k4_sig",  32'(oSignals[0]), 32'd1);
    checkValue("k4_busy", 32'(oBusy[0]),    32'd0);
    cycle();                                         // k+5
    checkValue("k5_sig",  32'(oSignals[0]), 32'd0);
    checkValue("k5_busy", 32'(oBusy[0]),    32'd1);

    // One-cycle runt request during the low hold.
    iSignal = 2'b01;
    cycle();
    checkValue("runt_pend6", 32'(oPending[0]), 32'(LATCH));
    iSignal = 2'b00;
    cycle();
    checkValue("runt_pend7", 32'(oPending[0]), 32'(LATCH));
    checkValue("runt_sig7",  32'(oSignals[0]), 32'd0);
    cycle();
    checkValue("runt_sig8",  32'(oSignals[0]), 32'(LATCH));
    for (int c = 0; c < 6; c++) cycle();

    // Clock-enable freeze mid-hold on lane 1.
    iSignal = 2'b10;
    cycle();
    cycle();
    iEna = 1'b0;
    iSignal = 2'b00;
    for (int c = 0; c < 3; c++) begin
      cycle();
      checkValue("frz_sig",  32'(oSignals[1]), 32'd1);
      checkValue("frz_busy", 32'(oBusy[1]),    32'd1);
    end
    iEna = 1'b1;
    for (int c = 0; c < 6; c++) cycle();
    checkValue("frz_done", 32'(oSignals[1]), 32'd0);

    // Synchronous reset wins over a deasserted enable.
    iSignal = 2'b11;
    cycle();
    cycle();
    iEna    = 1'b0;
    iSRst_n = 1'b0;
    cycle();
    checkValue("srst_sig",  32'(oSignals), 32'(RSTV));
    checkValue("srst_busy", 32'(oBusy),    32'd0);
    checkValue("srst_pend", 32'(oPending), 32'd0);
    iSRst_n = 1'b1;
    iEna    = 1'b1;
    iSignal = '0;
    for (int c = 0; c < 5; c++) cycle();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      iSignal = N'($urandom_range(0, (1 << N) - 1));
      iEna    = ($urandom_range(0, 7) != 0);
      iSRst_n = ($urandom_range(0, 60) != 0);
      cycle();
    end
    iSRst_n = 1'b1;
    iEna    = 1'b1;
    cycle();
    checkValue("sb_drain", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
